alu_exec_unit: RTL

- Execute-stage ALU; directly downstream of the ALU control decoder, consuming its 4-bit ALUControl code plus two 32-bit operands.
- Logic, add/sub and compare ops complete in one cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to keep the barrel shifter off the critical path.
- Valid/ready on both sides; busy and flush connect to the hazard unit.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_exec_unit_comb.sv | 29 ++
 rtl/alu_exec_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes from the ALU control
// decoder, execution FSM states and the default datapath width.
package alu_pkg;

    localparam int ALU_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_XOR  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_ADDI = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle datapath for logic, add/sub and compare ops. Shift codes and
// unassigned codes produce zero; shifts are handled by the iterative engine.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] value_o
);

    always_comb begin
        // NOTE: default assigned first so no path leaves value_o unassigned (no latch).
        value_o = '0;
        case (op_i)
            ALU_AND:           value_o = a_i & b_i;
            ALU_OR:            value_o = a_i | b_i;
            ALU_XOR:           value_o = a_i ^ b_i;
            ALU_ADD, ALU_ADDI: value_o = a_i + b_i;
            ALU_SUB:           value_o = a_i - b_i;
            ALU_SLT:           value_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:          value_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:           value_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle ops via alu_comb,
// shifts iterated SHIFT_STEP bits per cycle in a working register.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = ALU_XLEN,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int                CNT_W = 6;
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(SHIFT_STEP);

    exec_state_e      state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    alu_op_e          in_op;
    logic             accept;
    logic [XLEN-1:0]  comb_value;
    logic [CNT_W-1:0] step_amt;
    logic [CNT_W-1:0] cnt_next;
    logic [XLEN-1:0]  shifted;

    assign in_op    = alu_op_e'(alu_control);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

    alu_comb #(.XLEN(XLEN)) u_comb (
        .op_i    (in_op),
        .a_i     (operand_a),
        .b_i     (operand_b),
        .value_o (comb_value)
    );

    // Each shift cycle moves by min(remaining, SHIFT_STEP) bits.
    assign step_amt = (cnt_q < STEP) ? cnt_q : STEP;
    assign cnt_next = cnt_q - step_amt;

    always_comb begin
        shifted = work_q;
        case (op_q)
            ALU_SLL: shifted = work_q << step_amt;
            ALU_SRL: shifted = work_q >> step_amt;
            ALU_SRA: shifted = unsigned'($signed(work_q) >>> step_amt);
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            op_d = in_op;
            if (is_shift_op(in_op)) begin
                work_d = operand_a;
                cnt_d  = {1'b0, operand_b[4:0]};
                if (operand_b[4:0] == 5'd0) begin
                    result_d = operand_a;
                    state_d  = DONE;
                end else begin
                    // Result reads zero while shifting; partial values stay internal.
                    result_d = '0;
                    state_d  = SHIFT;
                end
            end else begin
                result_d = comb_value;
                state_d  = DONE;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    work_d = shifted;
                    cnt_d  = cnt_next;
                    if (cnt_next == '0) begin
                        result_d = shifted;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= ALU_AND;
            result_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
